// File: rtl/instr_register_pkg.sv
// Shared types and default sizes for the instruction register with in-block ALU.
package instr_register_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned OPCODE_W   = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [DEF_DATA_W-1:0]   operand_t;
  typedef logic signed [2*DEF_DATA_W-1:0] result_t;

  // Field order fixes the bit layout of instruction_word (opcode in the MSBs).
  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
    logic     div_zero;
  } instr_t;

  // Packed width of one entry for a given operand width; equals $bits(instr_t) at the default.
  function automatic int unsigned instr_width(input int unsigned data_w);
    return OPCODE_W + 4 * data_w + 1;
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational stage-2 ALU: sign-extends both operands to 2*DATA_W and computes the
// result and the divide-by-zero flag.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  opcode_t                    i_opcode,
  input  logic signed [DATA_W-1:0]   i_op_a,
  input  logic signed [DATA_W-1:0]   i_op_b,
  output logic signed [2*DATA_W-1:0] o_result,
  output logic                       o_div_zero
);

  logic signed [2*DATA_W-1:0] w_a_ext;
  logic signed [2*DATA_W-1:0] w_b_ext;

  // Doubling the width makes the full product and MIN/-1 division overflow-free.
  assign w_a_ext = {{DATA_W{i_op_a[DATA_W-1]}}, i_op_a};
  assign w_b_ext = {{DATA_W{i_op_b[DATA_W-1]}}, i_op_b};

  // Operation decode; DIV/MOD by zero yield 0 and raise the flag.
  always_comb begin
    o_result   = '0;
    o_div_zero = 1'b0;
    case (i_opcode)
      ZERO:  o_result = '0;
      PASSA: o_result = w_a_ext;
      PASSB: o_result = w_b_ext;
      ADD:   o_result = w_a_ext + w_b_ext;
      SUB:   o_result = w_a_ext - w_b_ext;
      MULT:  o_result = w_a_ext * w_b_ext;
      DIV: begin
        if (w_b_ext == '0) o_div_zero = 1'b1;
        else               o_result   = w_a_ext / w_b_ext;
      end
      MOD: begin
        if (w_b_ext == '0) o_div_zero = 1'b1;
        else               o_result   = w_a_ext % w_b_ext;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_alu.sv
// DEPTH-entry instruction register with a 2-stage write pipeline (capture, then ALU+write),
// registered reads with per-entry valid bits and write-to-read bypass.
// Optional build macro INSTR_REG_PARITY_EN adds per-entry even parity and a parity_err output.
module instr_register_alu
  import instr_register_pkg::*;
#(
  parameter int unsigned  DATA_W  = DEF_DATA_W,
  parameter int unsigned  DEPTH   = DEF_DEPTH,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned INSTR_W = instr_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_en,
  input  logic                     clear_en,
  input  logic signed [DATA_W-1:0] operand_a,
  input  logic signed [DATA_W-1:0] operand_b,
  input  opcode_t                  opcode,
  input  logic [PTR_W-1:0]         write_pointer,
  input  logic [PTR_W-1:0]         read_pointer,
  output logic [INSTR_W-1:0]       instruction_word,
  output logic                     read_valid,
  output logic                     busy
`ifdef INSTR_REG_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  // Same layout as instr_t, sized by this instance's DATA_W.
  typedef struct packed {
    opcode_t                    opcode;
    logic signed [DATA_W-1:0]   op_a;
    logic signed [DATA_W-1:0]   op_b;
    logic signed [2*DATA_W-1:0] result;
    logic                       div_zero;
  } entry_t;

  // Stage-1 capture registers
  logic                     r_s1_vld;
  opcode_t                  r_s1_opcode;
  logic signed [DATA_W-1:0] r_s1_a;
  logic signed [DATA_W-1:0] r_s1_b;
  logic [PTR_W-1:0]         r_s1_ptr;

  // Stage-2 / storage
  logic signed [2*DATA_W-1:0] w_alu_result;
  logic                       w_alu_div_zero;
  entry_t                     w_wr_entry;
  logic                       w_wr_en;
  entry_t                     r_mem [DEPTH];
  logic [DEPTH-1:0]           r_valid;
  logic [DEPTH-1:0]           w_valid_d;

  // Read port
  logic   w_bypass;
  entry_t r_rd_entry;
  logic   r_rd_valid;

  instr_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_opcode   (r_s1_opcode),
    .i_op_a     (r_s1_a),
    .i_op_b     (r_s1_b),
    .o_result   (w_alu_result),
    .o_div_zero (w_alu_div_zero)
  );

  assign w_wr_en    = r_s1_vld;
  assign w_wr_entry = '{opcode:   r_s1_opcode,
                        op_a:     r_s1_a,
                        op_b:     r_s1_b,
                        result:   w_alu_result,
                        div_zero: w_alu_div_zero};
  assign w_bypass   = w_wr_en && (r_s1_ptr == read_pointer);

  // Stage 1: capture the request; contents hold when idle, only the valid flag drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_opcode <= ZERO;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_ptr    <= '0;
    end else begin
      r_s1_vld <= load_en;
      if (load_en) begin
        r_s1_opcode <= opcode;
        r_s1_a      <= operand_a;
        r_s1_b      <= operand_b;
        r_s1_ptr    <= write_pointer;
      end
    end
  end

  // Stage 2: write the computed entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_s1_ptr] <= w_wr_entry;
    end
  end

  // Valid next-state: clear first, then a concurrent write re-validates its own entry.
  always_comb begin
    w_valid_d = r_valid;
    if (clear_en) w_valid_d = '0;
    if (w_wr_en)  w_valid_d[r_s1_ptr] = 1'b1;
  end

  // Valid bit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_valid <= '0;
    else          r_valid <= w_valid_d;
  end

  // Registered read; the pre-clear valid bit is returned unless the entry is being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_entry <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_entry <= w_bypass ? w_wr_entry : r_mem[read_pointer];
      r_rd_valid <= w_bypass | r_valid[read_pointer];
    end
  end

  assign instruction_word = r_rd_entry;
  assign read_valid       = r_rd_valid;
  assign busy             = r_s1_vld;

`ifdef INSTR_REG_PARITY_EN
  // Even parity covers everything except div_zero (bit 0).
  logic [DEPTH-1:0] r_par;
  logic             w_wr_par;
  logic             w_rd_par_err;
  logic             r_parity_err;
  entry_t           w_rd_raw;

  assign w_wr_par     = ^w_wr_entry[INSTR_W-1:1];
  assign w_rd_raw     = r_mem[read_pointer];
  assign w_rd_par_err = w_bypass ? 1'b0
                                 : ((^w_rd_raw[INSTR_W-1:1]) != r_par[read_pointer]);

  // Parity storage, written alongside the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_par           <= '0;
    else if (w_wr_en) r_par[r_s1_ptr] <= w_wr_par;
  end

  // Parity check registered with the read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_parity_err <= 1'b0;
    else          r_parity_err <= w_rd_par_err;
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
- Parametrised successor to the instruction register: DEPTH-entry store of {opcode, operand_a, operand_b, result, flags}.
- The result is computed in-block through a 2-stage write pipeline.
- Reads are registered and carry per-entry valid bits, with write-to-read bypass.
- Sits between the testbench interface and future execution logic; driven through the tb_ifc-style interface in the top-level netlist.

Parameters:
- DATA_W, 32, operand width in bits; signed.
- DEPTH, 32, number of register entries; a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk, input, 1, single clock for all logic.
- reset_n, input, 1, asynchronous active-low reset.
- load_en, input, 1, write request; sampled on posedge clk.
- clear_en, input, 1, clears all valid bits.
- operand_a, input, DATA_W, signed operand A.
- operand_b, input, DATA_W, signed operand B.
- opcode, input, opcode_t, operation select.
- write_pointer, input, PTR_W, destination entry.
- read_pointer, input, PTR_W, source entry.
- instruction_word, output, instr_t, registered read data.
- read_valid, output, 1, valid bit of the entry returned in instruction_word.
- busy, output, 1, high while a write is in flight in stage 1.

Behaviour:
- Reset (async, reset_n=0):
  - All entries zeroed; all valid bits cleared.
  - Stage-1 register: s1_vld=0, contents 0.
  - instruction_word=0, read_valid=0, busy=0.
  - A write in flight at reset assertion is discarded.
- Stage 1 (cycle N): if load_en=1, capture opcode, operand_a, operand_b and write_pointer, and set s1_vld=1; otherwise s1_vld=0. busy=s1_vld.
- Stage 2 (cycle N+1): if s1_vld, compute result combinationally from the stage-1 registers. At the posedge ending N+1, write the entry and set its valid bit. Write latency: the entry is visible 2 edges after load_en.
- Back-to-back loads every cycle are legal; throughput is 1 per cycle. No backpressure.
- Result width is 2*DATA_W, signed; operands are sign-extended before the operation.
  - ZERO: 0.
  - PASSA: a.
  - PASSB: b.
  - ADD: a+b.
  - SUB: a-b.
  - MULT: full signed product, no truncation.
  - DIV: a/b, truncating toward zero.
  - MOD: a%b, sign follows a.
- Divide by zero (DIV or MOD with b=0): result=0 and the entry's div_zero flag is set. The flag is 0 for all other cases.
- Read path: at each posedge, instruction_word <= entry[read_pointer] and read_valid <= valid[read_pointer]. Read latency is 1 cycle; reads are always enabled.
- Bypass: if stage 2 writes entry X in the same cycle that read_pointer==X, instruction_word receives the new data and read_valid=1.
- clear_en: clears all valid bits at the posedge; entry data is retained.
- clear_en together with a stage-2 write to X: the write wins for X, so valid[X]=1; all other entries are cleared.
- clear_en together with a read: the read returns the pre-clear valid bit, except under the bypass rule above.
- Pointer wrap: pointers are PTR_W bits wide, so every value maps to an entry; no out-of-range case exists.
- Same write_pointer on consecutive loads: the later write overwrites the earlier one.

Optional Feature:
- Macro: INSTR_REG_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit over {opcode, operand_a, operand_b, result}, generated in stage 2.
  - Output port parity_err (1 bit) is registered with read data: 1 if the parity recomputed over the read entry mismatches the stored bit.
  - Reset value of parity_err is 0.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- instr_register_pkg holds:
  - opcode_t: 4-bit enum ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
  - operand_t and result_t widths.
  - instr_t: packed struct of opcode, op_a, op_b, result, div_zero.
  - Default DATA_W and DEPTH constants.
- instr_register_pkg is parametrised through the defaults used by the block.
- Sub-module instr_alu: the purely combinational stage-2 result and div_zero computation, instantiated once.

Test Plan:
- Reset mid-write: load_en with ADD 5,3 to ptr 2, then reset_n=0 in the next cycle → after release, read ptr 2 gives instruction_word=0 and read_valid=0.
- Pipelined writes: load 4 consecutive cycles with ADD 7,-2 → p0; SUB 7,-2 → p1; MULT -3,4 → p2; DIV -7,2 → p3 → on read, results are 5, 9, -12, -3, each with read_valid=1. busy is high for 4 cycles.
- Divide by zero: DIV 9,0 and MOD 9,0 → result=0 and div_zero=1. MOD -7,2 → -1 with div_zero=0.
- Bypass: load PASSA 0x1234 to ptr 5 while holding read_pointer=5 → instruction_word shows 0x1234 on the edge the entry is written (edge N+2).
- Clear collision: fill ptrs 0–3, then assert clear_en on the same edge as the stage-2 write to ptr 1 → read_valid is 0 for ptrs 0, 2, 3 and 1 for ptr 1.
- Width sweep: DATA_W=8, DEPTH=4 with MULT -128,-128 → 16384 with no truncation. write_pointer=3 then 0 shows wrap with no aliasing. With INSTR_REG_PARITY_EN defined, a forced bit flip in an entry gives parity_err=1.
